int_sched_ctrl: RTL
===================

// Module: int_sched_ctrl
// PURPOSE
//  Sequences the 4-source vectored interrupt path. Latches done pulses from four
//  devices into sticky pending bits and applies an enable mask. Selects one winner
//  by fixed or round-robin priority and raises a request to the CPU. Completes the
//  int_ack / end-of-interrupt handshake and drives the vector int_addr = {ADDR_PREFIX, id}.
//  Sits between the device done lines and the CPU interrupt inputs.
// PARAMETERS
//  RR_EN        0              0: fixed priority (done1 highest .. done4 lowest); 1: round-robin
//  ADDR_PREFIX  30'h3FFFFFFF   upper 30 bits of every vector address
// PORTS
//  clk         in   1   system clock, all state updates on rising edge
//  rst         in   1   asynchronous, active-high reset
//  done1       in   1   device 1 completion, sampled every cycle (high = event)
//  done2       in   1   device 2 completion
//  done3       in   1   device 3 completion
//  done4       in   1   device 4 completion
//  en_we       in   1   enable-mask write strobe
//  en_wdata    in   4   new enable mask, bit i-1 enables source i
//  int_ack     in   1   CPU acknowledge of int_req (one-cycle pulse)
//  int_eoi     in   1   CPU end-of-interrupt, ISR finished (one-cycle pulse)
//  int_req     out  1   interrupt request to CPU
//  int_addr    out  32  vector address {ADDR_PREFIX, int_id}
//  int_id      out  2   selected source: 0=done1 .. 3=done4
//  busy        out  1   high while in REQ or SERV
//  pending     out  4   sticky pending bits, bit i-1 = source i
//  int_en      out  4   current enable mask
// BEHAVIOUR
//  Reset (async): state=IDLE; pending=0; int_en=4'hF; int_id=0; rr_ptr=0; int_req=0; busy=0.
//   int_addr={ADDR_PREFIX,2'b00}. Reset mid-handshake abandons it; no ack or eoi is owed.
//  Pending: pending[i] is set on any cycle with done(i+1)=1. It is cleared only by the grant.
//   If set and grant clear hit the same bit in one cycle, set wins (new event kept).
//  Mask: en_we loads int_en next edge. Masked bits stay pending but are not eligible.
//   Masking the selected source after selection does not cancel it.
//  eligible = pending & int_en.
//  FSM states IDLE, REQ, SERV:
//   IDLE: if eligible != 0, latch winner into int_id and go to REQ next edge.
//    Otherwise stay. int_ack and int_eoi are ignored.
//   REQ: int_req=1 (registered, so first asserted the cycle after the IDLE decision).
//    Winner is locked, with no preemption by higher-priority arrivals.
//    On int_ack=1: clear pending[int_id] and go to SERV. int_eoi is ignored.
//   SERV: int_req=0. int_ack is ignored. On int_eoi=1: go to IDLE.
//    If RR_EN=1, rr_ptr = int_id+1 mod 4 (wrap 3->0).
//  Priority: RR_EN=0 picks the lowest eligible index. RR_EN=1 picks the first eligible
//   index scanning from rr_ptr upward with wrap.
//  int_addr is combinational from the int_id register. It is stable from REQ entry until
//   the next IDLE->REQ transition.
//  Minimum latency from done pulse to int_req high: 2 cycles (latch, then select).
//  Minimum turnaround from int_eoi to the next int_req: 2 cycles (IDLE, REQ).
//  busy = (state != IDLE).
// TESTING
//  1. Reset: assert rst mid-REQ -> int_req=0, pending=0, int_en=F,
//     int_addr=FFFFFFFC immediately.
//  2. Single source: done3 pulse -> int_req high 2 cycles later, int_addr=FFFFFFFE.
//     Then ack -> pending=0, busy=1. Then eoi -> IDLE, busy=0.
//  3. Fixed priority (RR_EN=0): done4 and done2 in the same cycle -> first vector FFFFFFFD.
//     After eoi, second vector FFFFFFFF.
//  4. Round-robin (RR_EN=1): all four done held high, 8 services -> ids 0,1,2,3,0,1,2,3,
//     including wrap 3->0.
//  5. Mask: en_wdata=4'b1110 and done1 -> pending=0001, no int_req.
//     Then write F -> int_req, vector FFFFFFFC.
//  6. Collision: done2 high on the int_ack cycle for id 1 -> pending[1] stays 1.
//     Next service is again id 1. Stray ack in IDLE and stray eoi in REQ -> no state change.

Source files
------------

// File: rtl/int_sched_ctrl.sv
// Four-source vectored interrupt sequencer: sticky pending capture, enable masking,
// fixed or round-robin winner selection, and the int_ack / end-of-interrupt handshake.
module int_sched_ctrl #(
  parameter bit          RR_EN       = 1'b0,
  parameter logic [29:0] ADDR_PREFIX = 30'h3FFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done1,
  input  logic        done2,
  input  logic        done3,
  input  logic        done4,
  input  logic        en_we,
  input  logic [3:0]  en_wdata,
  input  logic        int_ack,
  input  logic        int_eoi,
  output logic        int_req,
  output logic [31:0] int_addr,
  output logic [1:0]  int_id,
  output logic        busy,
  output logic [3:0]  pending,
  output logic [3:0]  int_en
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned IDW  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

  state_e            state_q;
  logic [NSRC-1:0]   pending_q;
  logic [NSRC-1:0]   pending_d;
  logic [NSRC-1:0]   int_en_q;
  logic [NSRC-1:0]   int_en_d;
  logic [NSRC-1:0]   done_vec;
  logic [NSRC-1:0]   eligible;
  logic [NSRC-1:0]   clr_mask;
  logic [IDW-1:0]    int_id_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    scan_base;
  logic [IDW-1:0]    scan_idx;
  logic [IDW-1:0]    winner;
  logic              found;
  logic              grant;
  logic              int_req_q;
  logic              busy_q;

  assign done_vec = {done4, done3, done2, done1};
  assign eligible = pending_q & int_en_q;
  assign grant    = (state_q == REQ) && int_ack;

  // Scan start is the round-robin pointer, or index 0 for fixed priority.
  assign scan_base = RR_EN ? rr_ptr_q : IDW'(0);

  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      scan_idx = IDW'(scan_base + IDW'(i));
      if (!found && eligible[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // A new event on the granted bit in the same cycle outranks the clear.
  always_comb begin
    clr_mask  = grant ? (NSRC'(1) << int_id_q) : '0;
    pending_d = (pending_q & ~clr_mask) | done_vec;
    int_en_d  = en_we ? en_wdata : int_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      int_en_q  <= '1;
    end else begin
      pending_q <= pending_d;
      int_en_q  <= int_en_d;
    end
  end

  // Handshake sequencer; the winner is locked in int_id_q from IDLE until the next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      int_id_q  <= '0;
      rr_ptr_q  <= '0;
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            int_id_q  <= winner;
            state_q   <= REQ;
            int_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q   <= SERV;
            int_req_q <= 1'b0;
          end
        end
        SERV: begin
          if (int_eoi) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (RR_EN) begin
              rr_ptr_q <= IDW'(int_id_q + IDW'(1));
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign int_req  = int_req_q;
  assign int_id   = int_id_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign int_en   = int_en_q;
  assign int_addr = {ADDR_PREFIX, int_id_q};

endmodule
